ser2par_stream: RTL and testbench

Parametrised serial-to-parallel deserializer with word framing, output handshake and overflow detection. It accumulates PW/SW serial beats of SW bits each into a PW-bit word and presents completed words on a registered valid/ready output port. A start strobe realigns framing, and a sticky flag reports words lost to back-pressure. It sits between a serial link receiver (already sampled into the clk domain) and word-oriented downstream logic.

---
 rtl/ser2par_stream_pkg.sv | 12 +
 rtl/ser2par_shreg.sv | 29 ++
 rtl/ser2par_stream.sv | 101 ++++++++++
 tb/tb_ser2par_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ser2par_stream_pkg.sv
// Shared constants for the ser2par_stream deserializer: output-register states
// and the elaboration-time configuration check.
package ser2par_stream_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    function automatic bit s2p_cfg_ok(input int pw, input int sw);
        return (sw > 0) && (pw % sw == 0) && (pw / sw >= 2);
    endfunction

endpackage

// File: rtl/ser2par_shreg.sv
// SW-wide bidirectional shift register feeding the deserializer word buffer.
module ser2par_shreg #(
    parameter int PW = 64,
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] din,
    input  logic          shift,
    input  logic          lsbfirst,
    output logic [PW-1:0] q
);

    logic [PW-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift)
            sr_d = lsbfirst ? {din, sr_q[PW-1:SW]} : {sr_q[PW-SW-1:0], din};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign q = sr_q;

endmodule

// File: rtl/ser2par_stream.sv
// Serial-to-parallel deserializer: beat framing, registered valid/ready word
// output and a sticky flag for words lost to back-pressure.
module ser2par_stream
    import ser2par_stream_pkg::*;
#(
    parameter  int PW = 64,
    parameter  int SW = 1,
    localparam int CW = $clog2(PW/SW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] din,
    input  logic          shift,
    input  logic          start,
    input  logic          lsbfirst,
    output logic [PW-1:0] dout,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          clear_ovf
);

    localparam int N = PW / SW;

    if (!s2p_cfg_ok(PW, SW)) begin : g_cfg_bad
        $fatal(1, "ser2par_stream: PW must be a multiple of SW with PW/SW >= 2");
    end

    logic [PW-1:0] sr;
    logic [PW-1:0] word;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] dout_q, dout_d;
    logic          state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          last_beat, cmpl, ovf_set;

    ser2par_shreg #(.PW(PW), .SW(SW)) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .shift    (shift),
        .lsbfirst (lsbfirst),
        .q        (sr)
    );

    // The completed word must include the beat arriving on this edge.
    assign word      = lsbfirst ? {din, sr[PW-1:SW]} : {sr[PW-SW-1:0], din};
    assign last_beat = (count_q == CW'(N-1));
    assign cmpl      = shift && !start && last_beat;

    always_comb begin
        count_d = count_q;
        if (start)      count_d = shift ? CW'(1) : '0;
        else if (shift) count_d = last_beat ? '0 : count_q + CW'(1);
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ovf_set = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (cmpl) begin
                    dout_d  = word;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (cmpl) begin
                    if (ready_in) dout_d  = word;
                    else          ovf_set = 1'b1;
                end else if (ready_in) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        ovf_d = ovf_set ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dout_q  <= '0;
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout      = dout_q;
    assign valid_out = (state_q == ST_FULL);
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ser2par_stream.sv
// Scoreboard bench for ser2par_stream: an 8x1 and a 16x4 instance share clk/reset.
module tb_ser2par_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       din8, sh8, st8, lsb8, rdy8, clr8;
    logic [7:0] dout8;
    logic       vo8, ovf8;
    logic [2:0] cnt8;

    logic [3:0]  din16;
    logic        sh16, st16, lsb16, rdy16, clr16;
    logic [15:0] dout16;
    logic        vo16, ovf16;
    logic [1:0]  cnt16;

    logic [63:0] q8[$];
    logic [63:0] q16[$];
    int n_chk  = 0;
    int n_fail = 0;

    ser2par_stream #(.PW(8), .SW(1)) u_dut8 (
        .clk(clk), .reset(reset), .din(din8), .shift(sh8), .start(st8),
        .lsbfirst(lsb8), .dout(dout8), .valid_out(vo8), .ready_in(rdy8),
        .count(cnt8), .overflow(ovf8), .clear_ovf(clr8)
    );

    ser2par_stream #(.PW(16), .SW(4)) u_dut16 (
        .clk(clk), .reset(reset), .din(din16), .shift(sh16), .start(st16),
        .lsbfirst(lsb16), .dout(dout16), .valid_out(vo16), .ready_in(rdy16),
        .count(cnt16), .overflow(ovf16), .clear_ovf(clr16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            din8 = w[7-i];
            sh8  = 1'b1;
            tick();
        end
        sh8  = 1'b0;
        din8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            din16 = w[15-4*i -: 4];
            sh16  = 1'b1;
            tick();
        end
        sh16  = 1'b0;
        din16 = '0;
    endtask

    // A transfer happens on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && vo8 && rdy8) begin
            if (q8.size() == 0) chk("sb8_extra_word", 64'(dout8), 64'hDEAD);
            else                chk("sb8_word", 64'(dout8), q8.pop_front());
        end
        if (!reset && vo16 && rdy16) begin
            if (q16.size() == 0) chk("sb16_extra_word", 64'(dout16), 64'hDEAD);
            else                 chk("sb16_word", 64'(dout16), q16.pop_front());
        end
    end

    initial begin
        logic [7:0] w;
        logic [6:0] rest;
        reset = 1'b1;
        {din8, sh8, st8, lsb8, clr8} = '0;
        rdy8 = 1'b1;
        {din16, sh16, st16, lsb16, rdy16, clr16} = '0;
        tick();
        tick();
        chk("rst_dout", 64'(dout8), 64'h0);
        chk("rst_valid", 64'(vo8), 64'h0);
        chk("rst_count", 64'(cnt8), 64'h0);
        chk("rst_ovf", 64'(ovf8), 64'h0);
        reset = 1'b0;
        tick();

        // msb-first word
        q8.push_back(64'hB4);
        send8(8'hB4);
        chk("msb_dout", 64'(dout8), 64'hB4);
        chk("msb_valid", 64'(vo8), 64'h1);
        chk("msb_count", 64'(cnt8), 64'h0);
        tick();
        chk("msb_valid_drop", 64'(vo8), 64'h0);

        // same beats lsb-first
        lsb8 = 1'b1;
        q8.push_back(64'h2D);
        send8(8'hB4);
        chk("lsb_dout", 64'(dout8), 64'h2D);
        lsb8 = 1'b0;
        tick();

        // start realigns: 3-beat fragment discarded
        for (int i = 0; i < 3; i++) begin din8 = 1'b1; sh8 = 1'b1; tick(); end
        chk("frag_count", 64'(cnt8), 64'h3);
        st8 = 1'b1; din8 = 1'b1; tick();
        st8 = 1'b0;
        chk("start_count", 64'(cnt8), 64'h1);
        chk("start_novalid", 64'(vo8), 64'h0);
        rest = 7'b0100101;
        q8.push_back(64'hA5);
        for (int i = 0; i < 7; i++) begin din8 = rest[6-i]; sh8 = 1'b1; tick(); end
        sh8 = 1'b0;
        chk("start_dout", 64'(dout8), 64'hA5);
        chk("start_valid", 64'(vo8), 64'h1);

        // start on the final beat beats completion
        for (int i = 0; i < 7; i++) begin din8 = 1'b0; sh8 = 1'b1; tick(); end
        st8 = 1'b1; tick();
        chk("prio_novalid", 64'(vo8), 64'h0);
        chk("prio_count", 64'(cnt8), 64'h1);
        sh8 = 1'b0; tick();
        st8 = 1'b0;
        chk("start_noshift_count", 64'(cnt8), 64'h0);

        // held word plus partial word, then async reset mid-word
        rdy8 = 1'b0;
        send8(8'h96);
        chk("held_dout", 64'(dout8), 64'h96);
        for (int i = 0; i < 5; i++) begin din8 = 1'b1; sh8 = 1'b1; tick(); end
        sh8 = 1'b0;
        chk("mid_count", 64'(cnt8), 64'h5);
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(cnt8), 64'h0);
        chk("arst_valid", 64'(vo8), 64'h0);
        chk("arst_dout", 64'(dout8), 64'h0);
        tick();
        reset = 1'b0;
        rdy8  = 1'b1;
        q8.push_back(64'h3C);
        send8(8'h3C);
        chk("post_rst_dout", 64'(dout8), 64'h3C);
        tick();

        // back-to-back: ready rises only on each completing beat of the next word
        for (int k = 0; k < 4; k++) begin
            w = 8'($urandom_range(0, 255));
            q8.push_back(64'(w));
            for (int i = 0; i < 8; i++) begin
                din8 = w[7-i];
                sh8  = 1'b1;
                rdy8 = (k > 0) && (i == 7);
                tick();
            end
            chk("b2b_valid", 64'(vo8), 64'h1);
            chk("b2b_dout", 64'(dout8), 64'(w));
        end
        sh8 = 1'b0; rdy8 = 1'b1; tick();
        chk("b2b_ovf", 64'(ovf8), 64'h0);
        chk("b2b_drained", 64'(vo8), 64'h0);

        // 16x4 back-pressure and overflow
        q16.push_back(64'h1234);
        send16(16'h1234);
        chk("w16_valid", 64'(vo16), 64'h1);
        chk("w16_dout", 64'(dout16), 64'h1234);
        send16(16'h5678);
        chk("w16_ovf", 64'(ovf16), 64'h1);
        chk("w16_dout_held", 64'(dout16), 64'h1234);
        chk("w16_count", 64'(cnt16), 64'h0);
        rdy16 = 1'b1; tick();
        chk("w16_valid_drop", 64'(vo16), 64'h0);
        clr16 = 1'b1; tick();
        clr16 = 1'b0;
        chk("w16_ovf_clr", 64'(ovf16), 64'h0);

        // overflow set wins over clear in the same cycle
        rdy16 = 1'b0;
        q16.push_back(64'hABCD);
        send16(16'hABCD);
        for (int i = 0; i < 4; i++) begin
            din16 = 4'h1; sh16 = 1'b1; clr16 = (i == 3);
            tick();
        end
        sh16 = 1'b0; clr16 = 1'b0;
        chk("set_beats_clr", 64'(ovf16), 64'h1);
        chk("set_dout_held", 64'(dout16), 64'hABCD);
        clr16 = 1'b1; tick();
        clr16 = 1'b0;
        chk("clr_after", 64'(ovf16), 64'h0);
        rdy16 = 1'b1; tick();
        chk("w16_final_drop", 64'(vo16), 64'h0);

        tick();
        chk("sb8_left", 64'(q8.size()), 64'h0);
        chk("sb16_left", 64'(q16.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
